lcd_sequencer: RTL and testbench

Sequences the 9-bit `spi_master` display link. After reset it pulses the panel's hardware reset and plays an init ROM of commands, data bytes and millisecond delays. It then serves frame requests: it writes the address window (CASET/RASET/RAMWR), reads RGB565 pixels from the framebuffer and streams each pixel as two data words. It is the only source of `spi_master` input words.

---
 rtl/lcd_sequencer_pkg.sv | 36 +++
 rtl/lcd_init_rom.sv | 23 ++
 rtl/lcd_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_sequencer_pkg.sv
// rtl/lcd_sequencer_pkg.sv - shared codes and state encoding for the LCD link sequencer
package lcd_sequencer_pkg;

   localparam int DC_BIT = 8;

   localparam logic [1:0] ENT_CMD   = 2'b00;
   localparam logic [1:0] ENT_DATA  = 2'b01;
   localparam logic [1:0] ENT_DELAY = 2'b10;
   localparam logic [1:0] ENT_END   = 2'b11;

   localparam logic [7:0] OP_CASET = 8'h2A;
   localparam logic [7:0] OP_RASET = 8'h2B;
   localparam logic [7:0] OP_RAMWR = 8'h2C;

   typedef enum logic [3:0] {
      S_RST_LOW,
      S_RST_WAIT,
      S_INIT_FETCH,
      S_INIT_SEND,
      S_INIT_DELAY,
      S_READY,
      S_WIN_SEND,
      S_PIX_FETCH,
      S_PIX_HI,
      S_PIX_LO,
      S_FRAME_END
   } state_t;

   function automatic logic [8:0] mk_word(input logic dc, input logic [7:0] b);
      logic [8:0] w;
      w         = {1'b0, b};
      w[DC_BIT] = dc;
      return w;
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// rtl/lcd_init_rom.sv - panel init program: commands, data bytes, ms delays, end marker
module lcd_init_rom
   import lcd_sequencer_pkg::*;
#(
   parameter int INIT_LEN = 32,
   parameter int PTR_W    = $clog2(INIT_LEN)
) (
   input  logic [PTR_W-1:0] addr,
   output logic [9:0]       entry
);

   always_comb begin
      entry = {ENT_END, 8'h00};
      case (int'(addr))
         0:       entry = {ENT_CMD,   8'h01};
         1:       entry = {ENT_DELAY, 8'h05};
         2:       entry = {ENT_CMD,   8'h11};
         3:       entry = {ENT_DATA,  8'h55};
         default: entry = {ENT_END,   8'h00};
      endcase
   end

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - panel reset, init ROM playback and framebuffer streaming
// onto the 9-bit spi_master word link.
module lcd_sequencer
   import lcd_sequencer_pkg::*;
#(
   parameter int H_RES       = 240,
   parameter int V_RES       = 320,
   parameter int CLK_FREQ    = 25_000_000,
   parameter int RST_LOW_MS  = 10,
   parameter int RST_WAIT_MS = 120,
   parameter int INIT_LEN    = 32,
   parameter int ADDR_W      = $clog2(H_RES*V_RES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_req,
   input  logic              spi_idle,
   output logic [8:0]        spi_data,
   output logic              spi_avail,
   output logic              pixel_rd,
   output logic [ADDR_W-1:0] pixel_addr,
   input  logic [15:0]       pixel_data,
   output logic              lcd_rst_n,
   output logic              init_done,
   output logic              frame_busy,
   output logic              frame_done
);

   localparam int MS_CYCLES = CLK_FREQ / 1000;
   localparam int MS_W      = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam int PTR_W     = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
   localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES*V_RES - 1);
   localparam logic [15:0]       H_LAST    = 16'(H_RES - 1);
   localparam logic [15:0]       V_LAST    = 16'(V_RES - 1);

   state_t            state, state_d;
   logic [PTR_W-1:0]  ptr, ptr_d;
   logic [MS_W-1:0]   ms_cnt, ms_cnt_d, ms_cnt_nx;
   logic [7:0]        ms_el, ms_el_d, ms_el_nx;
   logic [7:0]        delay_ms, delay_d;
   logic              issued, issued_d, seen_busy, seen_busy_d;
   logic [3:0]        win_idx, win_idx_d;
   logic              fetch_ph, fetch_ph_d;
   logic [15:0]       px, px_d;
   logic              pending, pending_d;
   logic [ADDR_W-1:0] addr_d;
   logic              init_done_d, spi_avail_d;
   logic [8:0]        spi_data_d, word, win_word;
   logic              send, ms_tick, hs_done;
   logic [9:0]        entry;

   lcd_init_rom #(.INIT_LEN(INIT_LEN), .PTR_W(PTR_W)) u_rom (
      .addr  (ptr),
      .entry (entry)
   );

   always_comb begin
      win_word = mk_word(1'b0, OP_RAMWR);
      case (win_idx)
         4'd0:       win_word = mk_word(1'b0, OP_CASET);
         4'd1, 4'd2: win_word = mk_word(1'b1, 8'h00);
         4'd3:       win_word = mk_word(1'b1, H_LAST[15:8]);
         4'd4:       win_word = mk_word(1'b1, H_LAST[7:0]);
         4'd5:       win_word = mk_word(1'b0, OP_RASET);
         4'd6, 4'd7: win_word = mk_word(1'b1, 8'h00);
         4'd8:       win_word = mk_word(1'b1, V_LAST[15:8]);
         4'd9:       win_word = mk_word(1'b1, V_LAST[7:0]);
         default:    win_word = mk_word(1'b0, OP_RAMWR);
      endcase
   end

   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      ms_cnt_d    = '0;
      ms_el_d     = '0;
      delay_d     = delay_ms;
      issued_d    = issued;
      seen_busy_d = seen_busy;
      win_idx_d   = win_idx;
      fetch_ph_d  = fetch_ph;
      px_d        = px;
      addr_d      = pixel_addr;
      init_done_d = init_done;
      pending_d   = pending | (frame_req && (state != S_READY));
      spi_avail_d = 1'b0;
      spi_data_d  = spi_data;
      word        = '0;
      send        = 1'b0;
      ms_tick     = (ms_cnt == MS_LAST);
      ms_cnt_nx   = ms_tick ? '0 : ms_cnt + MS_W'(1);
      ms_el_nx    = ms_tick ? ms_el + 8'd1 : ms_el;
      hs_done     = issued && seen_busy && spi_idle;

      case (state)
         S_RST_LOW: begin
            if (ms_tick && (ms_el == 8'(RST_LOW_MS - 1))) state_d = S_RST_WAIT;
            else begin
               ms_cnt_d = ms_cnt_nx;
               ms_el_d  = ms_el_nx;
            end
         end
         S_RST_WAIT: begin
            if (ms_tick && (ms_el == 8'(RST_WAIT_MS - 1))) state_d = S_INIT_FETCH;
            else begin
               ms_cnt_d = ms_cnt_nx;
               ms_el_d  = ms_el_nx;
            end
         end
         S_INIT_FETCH: begin
            case (entry[9:8])
               ENT_CMD, ENT_DATA: state_d = S_INIT_SEND;
               ENT_DELAY: begin
                  ptr_d = ptr + PTR_W'(1);
                  if (entry[7:0] != 8'd0) begin
                     delay_d = entry[7:0];
                     state_d = S_INIT_DELAY;
                  end
               end
               default: begin
                  init_done_d = 1'b1;
                  state_d     = S_READY;
               end
            endcase
         end
         S_INIT_SEND: begin
            send = 1'b1;
            word = mk_word(entry[9:8] == ENT_DATA, entry[7:0]);
            if (hs_done) begin
               ptr_d   = ptr + PTR_W'(1);
               state_d = S_INIT_FETCH;
            end
         end
         S_INIT_DELAY: begin
            if (ms_tick && (ms_el == delay_ms - 8'd1)) state_d = S_INIT_FETCH;
            else begin
               ms_cnt_d = ms_cnt_nx;
               ms_el_d  = ms_el_nx;
            end
         end
         S_READY: begin
            if (frame_req || pending) begin
               pending_d = 1'b0;
               win_idx_d = '0;
               state_d   = S_WIN_SEND;
            end
         end
         S_WIN_SEND: begin
            send = 1'b1;
            word = win_word;
            if (hs_done) begin
               if (win_idx == 4'd10) state_d = S_PIX_FETCH;
               else win_idx_d = win_idx + 4'd1;
            end
         end
         S_PIX_FETCH: begin
            // first cycle strobes the read, second cycle captures the returned pixel
            if (!fetch_ph) fetch_ph_d = 1'b1;
            else begin
               fetch_ph_d = 1'b0;
               px_d       = pixel_data;
               state_d    = S_PIX_HI;
            end
         end
         S_PIX_HI: begin
            send = 1'b1;
            word = mk_word(1'b1, px[15:8]);
            if (hs_done) state_d = S_PIX_LO;
         end
         S_PIX_LO: begin
            send = 1'b1;
            word = mk_word(1'b1, px[7:0]);
            if (hs_done) begin
               if (pixel_addr == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = S_FRAME_END;
               end else begin
                  addr_d  = pixel_addr + ADDR_W'(1);
                  state_d = S_PIX_FETCH;
               end
            end
         end
         S_FRAME_END: state_d = S_READY;
         default:     state_d = S_RST_LOW;
      endcase

      if (send) begin
         if (!issued && spi_idle) begin
            spi_avail_d = 1'b1;
            spi_data_d  = word;
            issued_d    = 1'b1;
         end else if (issued && !spi_idle) begin
            seen_busy_d = 1'b1;
         end else if (hs_done) begin
            issued_d    = 1'b0;
            seen_busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_RST_LOW;
         ptr        <= '0;
         ms_cnt     <= '0;
         ms_el      <= '0;
         delay_ms   <= '0;
         issued     <= 1'b0;
         seen_busy  <= 1'b0;
         win_idx    <= '0;
         fetch_ph   <= 1'b0;
         px         <= '0;
         pending    <= 1'b0;
         spi_avail  <= 1'b0;
         spi_data   <= '0;
         pixel_rd   <= 1'b0;
         pixel_addr <= '0;
         lcd_rst_n  <= 1'b0;
         init_done  <= 1'b0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         ptr        <= ptr_d;
         ms_cnt     <= ms_cnt_d;
         ms_el      <= ms_el_d;
         delay_ms   <= delay_d;
         issued     <= issued_d;
         seen_busy  <= seen_busy_d;
         win_idx    <= win_idx_d;
         fetch_ph   <= fetch_ph_d;
         px         <= px_d;
         pending    <= pending_d;
         spi_avail  <= spi_avail_d;
         spi_data   <= spi_data_d;
         pixel_rd   <= (state_d == S_PIX_FETCH) && !fetch_ph_d;
         pixel_addr <= addr_d;
         lcd_rst_n  <= (state_d != S_RST_LOW);
         init_done  <= init_done_d;
         frame_busy <= state_d inside {S_WIN_SEND, S_PIX_FETCH, S_PIX_HI, S_PIX_LO};
         frame_done <= (state_d == S_FRAME_END);
      end
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - randomized self-checking bench for lcd_sequencer
module tb_lcd_sequencer;

   localparam int H_RES        = 4;
   localparam int V_RES        = 2;
   localparam int CLK_FREQ     = 10_000;
   localparam int MS_CYCLES    = CLK_FREQ / 1000;
   localparam int NPIX         = H_RES * V_RES;
   localparam int ADDR_W       = $clog2(NPIX);
   localparam int SPI_WORD_CYC = 18;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              frame_req = 1'b0;
   logic              spi_idle = 1'b1;
   logic [15:0]       pixel_data = '0;
   logic [8:0]        spi_data;
   logic              spi_avail, pixel_rd, lcd_rst_n, init_done, frame_busy, frame_done;
   logic [ADDR_W-1:0] pixel_addr;

   int tests = 0;
   int fails = 0;

   logic [8:0]  words[$];
   int          word_t[$];
   logic [8:0]  exp_q[$];
   logic [15:0] fb[NPIX];
   int          cyc = 0, busy_cnt = 0, hold_cnt = 0, proto_err = 0, fd_count = 0;
   logic        prev_avail = 1'b0, hold_req = 1'b0;

   lcd_sequencer #(
      .H_RES(H_RES), .V_RES(V_RES), .CLK_FREQ(CLK_FREQ),
      .RST_LOW_MS(10), .RST_WAIT_MS(120), .INIT_LEN(32), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .frame_req(frame_req), .spi_idle(spi_idle),
      .spi_data(spi_data), .spi_avail(spi_avail), .pixel_rd(pixel_rd),
      .pixel_addr(pixel_addr), .pixel_data(pixel_data), .lcd_rst_n(lcd_rst_n),
      .init_done(init_done), .frame_busy(frame_busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // spi_master model: each accepted word keeps idle low for SPI_WORD_CYC cycles
   always @(negedge clk) begin
      cyc++;
      if (spi_avail === 1'b1) begin
         if (prev_avail || !spi_idle) proto_err++;
         words.push_back(spi_data);
         word_t.push_back(cyc);
         busy_cnt = SPI_WORD_CYC;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      prev_avail = (spi_avail === 1'b1);
      if (hold_req) begin
         hold_cnt = 500;
         hold_req = 1'b0;
      end else if (hold_cnt > 0) begin
         hold_cnt--;
      end
      if (frame_done === 1'b1) fd_count++;
      spi_idle = (busy_cnt == 0) && (hold_cnt == 0);
   end

   always @(posedge clk) if (pixel_rd === 1'b1) pixel_data <= fb[pixel_addr];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
      $fatal(1);
   end

   function automatic void add_frame_exp();
      int hl, vl;
      hl = H_RES - 1;
      vl = V_RES - 1;
      exp_q.push_back(9'h02A);
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h100 | 9'((hl / 256) % 256));
      exp_q.push_back(9'h100 | 9'(hl % 256));
      exp_q.push_back(9'h02B);
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h100);
      exp_q.push_back(9'h100 | 9'((vl / 256) % 256));
      exp_q.push_back(9'h100 | 9'(vl % 256));
      exp_q.push_back(9'h02C);
      for (int a = 0; a < NPIX; a++) begin
         exp_q.push_back(9'h100 | 9'(int'(fb[a]) / 256));
         exp_q.push_back(9'h100 | 9'(int'(fb[a]) % 256));
      end
   endfunction

   function automatic int first_diff();
      if (words.size() != exp_q.size()) return -2;
      for (int i = 0; i < words.size(); i++)
         if (words[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic void randomize_fb();
      for (int a = 0; a < NPIX; a++) fb[a] = 16'($urandom_range(0, 65535));
   endfunction

   task automatic pulse_req();
      @(posedge clk); #1;
      frame_req = 1'b1;
      @(posedge clk); #1;
      frame_req = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int f0;
      f0 = fd_count;
      for (int i = 0; i < budget && fd_count < f0 + n; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n, t0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (spi_avail !== 1'b0)  begin fails++; $display("FAIL rst_spi_avail got %b exp 0", spi_avail); end
      tests++; if (spi_data !== 9'h000) begin fails++; $display("FAIL rst_spi_data got %h exp 000", spi_data); end
      tests++; if (pixel_rd !== 1'b0)   begin fails++; $display("FAIL rst_pixel_rd got %b exp 0", pixel_rd); end
      tests++; if (pixel_addr !== '0)   begin fails++; $display("FAIL rst_pixel_addr got %0d exp 0", pixel_addr); end
      tests++; if (init_done !== 1'b0)  begin fails++; $display("FAIL rst_init_done got %b exp 0", init_done); end
      tests++; if (frame_busy !== 1'b0) begin fails++; $display("FAIL rst_frame_busy got %b exp 0", frame_busy); end
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
      tests++; if (lcd_rst_n !== 1'b0)  begin fails++; $display("FAIL rst_lcd_rst_n got %b exp 0", lcd_rst_n); end
      words.delete(); word_t.delete();
      rst = 1'b1;
      n = 0;
      while (n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (lcd_rst_n === 1'b1) break;
      end
      tests++;
      if (n != 10 * MS_CYCLES) begin fails++; $display("FAIL rst_low_len got %0d cycles exp %0d", n, 10 * MS_CYCLES); end
      t0 = cyc;
      for (int i = 0; i < 3000 && words.size() == 0; i++) @(posedge clk);
      tests++;
      if (words.size() == 0 || word_t[0] - t0 < 120 * MS_CYCLES) begin
         fails++;
         $display("FAIL rst_wait_len got %0d cycles exp >= %0d", (words.size() == 0) ? -1 : word_t[0] - t0, 120 * MS_CYCLES);
      end
   endtask

   task automatic test_init();
      int extra;
      for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(posedge clk);
      #1;
      tests++;
      if (init_done !== 1'b1) begin fails++; $display("FAIL init_done got %b exp 1", init_done); end
      tests++;
      if (words.size() != 3 || words[0] !== 9'h001 || words[1] !== 9'h011 || words[2] !== 9'h155) begin
         fails++;
         $display("FAIL init_words got n=%0d first=%h exp 001 011 155", words.size(), (words.size() > 0) ? words[0] : 9'h1ff);
      end else begin
         // delay entry costs its own fetch cycle plus exactly 5 ms
         extra = (word_t[1] - word_t[0]) - (word_t[2] - word_t[1]);
         tests++;
         if (extra != 5 * MS_CYCLES + 1) begin fails++; $display("FAIL init_delay got %0d exp %0d", extra, 5 * MS_CYCLES + 1); end
      end
      repeat (200) @(posedge clk);
      #1;
      tests++;
      if (words.size() != 3 || init_done !== 1'b1) begin
         fails++;
         $display("FAIL init_quiet got n=%0d done=%b exp 3 1", words.size(), init_done);
      end
   endtask

   task automatic test_frame_ramp();
      int f0, d;
      for (int a = 0; a < NPIX; a++) fb[a] = 16'(a);
      words.delete(); exp_q.delete();
      add_frame_exp();
      f0 = fd_count;
      pulse_req();
      wait_frames(1, 4000);
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; $display("FAIL ramp_words idx %0d got n=%0d exp n=%0d", d, words.size(), exp_q.size()); end
      tests++;
      if (fd_count - f0 != 1) begin fails++; $display("FAIL ramp_done got %0d pulses exp 1", fd_count - f0); end
      tests++;
      if (pixel_addr !== '0 || frame_busy !== 1'b0) begin
         fails++;
         $display("FAIL ramp_end got addr=%0d busy=%b exp 0 0", pixel_addr, frame_busy);
      end
   endtask

   task automatic test_random_frames();
      int f0, d;
      for (int k = 0; k < 3; k++) begin
         randomize_fb();
         words.delete(); exp_q.delete();
         add_frame_exp();
         repeat ($urandom_range(1, 40)) @(posedge clk);
         f0 = fd_count;
         pulse_req();
         wait_frames(1, 4000);
         d = first_diff();
         tests++;
         if (d != -1 || fd_count - f0 != 1) begin
            fails++;
            $display("FAIL rand_frame%0d idx %0d got n=%0d done=%0d exp n=%0d done=1", k, d, words.size(), fd_count - f0, exp_q.size());
         end
      end
   endtask

   task automatic test_back_to_back();
      int f0, d;
      randomize_fb();
      words.delete(); exp_q.delete();
      add_frame_exp();
      add_frame_exp();
      f0 = fd_count;
      pulse_req();
      for (int i = 0; i < 100 && frame_busy !== 1'b1; i++) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         repeat ($urandom_range(10, 100)) @(posedge clk);
         pulse_req();
      end
      wait_frames(2, 6000);
      repeat (800) @(posedge clk);
      #1;
      tests++;
      if (fd_count - f0 != 2) begin fails++; $display("FAIL b2b_frames got %0d exp 2", fd_count - f0); end
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; $display("FAIL b2b_words idx %0d got n=%0d exp n=%0d", d, words.size(), exp_q.size()); end
   endtask

   task automatic test_idle_hold();
      int n0, d;
      randomize_fb();
      words.delete(); exp_q.delete();
      add_frame_exp();
      pulse_req();
      for (int i = 0; i < 1000 && words.size() < 9; i++) @(posedge clk);
      #1;
      hold_req = 1'b1;
      @(negedge clk); #1;
      n0 = words.size();
      repeat (490) @(posedge clk);
      #1;
      tests++;
      if (words.size() != n0) begin fails++; $display("FAIL hold_quiet got %0d words exp %0d", words.size(), n0); end
      wait_frames(1, 5000);
      d = first_diff();
      tests++;
      if (d != -1) begin fails++; $display("FAIL hold_words idx %0d got n=%0d exp n=%0d", d, words.size(), exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      int f0;
      randomize_fb();
      words.delete();
      pulse_req();
      for (int i = 0; i < 2000 && words.size() < 20; i++) @(posedge clk);
      #1;
      f0 = fd_count;
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (spi_avail !== 1'b0 || lcd_rst_n !== 1'b0 || frame_busy !== 1'b0 || init_done !== 1'b0) begin
         fails++;
         $display("FAIL midrst_outputs got avail=%b rst_n=%b busy=%b done=%b exp 0 0 0 0", spi_avail, lcd_rst_n, frame_busy, init_done);
      end
      rst = 1'b1;
      words.delete(); word_t.delete();
      for (int i = 0; i < 3000 && init_done !== 1'b1; i++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if (words.size() != 3 || words[0] !== 9'h001 || words[1] !== 9'h011 || words[2] !== 9'h155 || init_done !== 1'b1) begin
         fails++;
         $display("FAIL midrst_replay got n=%0d done=%b exp 3 words 001 011 155 done=1", words.size(), init_done);
      end
      tests++;
      if (fd_count != f0) begin fails++; $display("FAIL midrst_no_done got %0d exp %0d", fd_count, f0); end
   endtask

   task automatic test_protocol();
      tests++;
      if (proto_err != 0) begin fails++; $display("FAIL spi_protocol got %0d violations exp 0", proto_err); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_frame_ramp();
      test_random_frames();
      test_back_to_back();
      test_idle_hold();
      test_reset_mid();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
